ring_counter: RTL and testbench



---
 rtl/ring_counter_pkg.sv | 27 ++
 rtl/ring_counter_stage.sv | 29 ++
 rtl/ring_counter.sv | 44 ++++
 tb/tb_ring_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
package ring_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // One-hot value with only bit (width-1) set.
  function automatic logic [31:0] seed_of(input int unsigned width);
    logic [31:0] seed;
    seed = 32'd0;
    seed[width-1] = 1'b1;
    return seed;
  endfunction

  function automatic logic is_onehot(input logic [31:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return (cnt == 1) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/ring_counter_stage.sv
// One ring stage: a flop with async clear and sync preset, both loading its seed bit.
module ring_counter_stage
  import ring_counter_pkg::*;
#(
  parameter logic SEED_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic prst_i,
  input  logic d_i,
  output logic q_o
);

  logic bit_q;

  // Clear dominates preset; both load the seed bit.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      bit_q <= SEED_BIT;
    end else if (prst_i) begin
      bit_q <= SEED_BIT;
    end else begin
      bit_q <= d_i;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/ring_counter.sv
// One-hot ring counter rotating right once per clock.
// Optional RCOUNTER_SELFCORRECT_EN reloads SEED from any non-one-hot state.
module ring_counter
  import ring_counter_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(seed_of(WIDTH))
) (
  input  logic             in_clk,
  input  logic             in_clr,
  input  logic             in_prst,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] ring_q;
  logic [WIDTH-1:0] ring_d;

  // Next state on a plain shift edge: rotate right, bit 0 wraps to the MSB.
  always_comb begin
    ring_d = {ring_q[0], ring_q[WIDTH-1:1]};
`ifdef RCOUNTER_SELFCORRECT_EN
    if (!is_onehot(32'(ring_q))) begin
      ring_d = SEED;
    end else begin
      ring_d = {ring_q[0], ring_q[WIDTH-1:1]};
    end
`endif
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    ring_counter_stage #(
      .SEED_BIT (SEED[g])
    ) u_stage (
      .clk_i  (in_clk),
      .clr_i  (in_clr),
      .prst_i (in_prst),
      .d_i    (ring_d[g]),
      .q_o    (ring_q[g])
    );
  end

  assign o_q = ring_q;

endmodule

// File: tb/tb_ring_counter.sv
// Directed, table-driven bench for ring_counter (WIDTH=4, WIDTH=8, non-one-hot seeds).
`timescale 1ns/1ps
module tb_ring_counter;
  import ring_counter_pkg::*;

  logic       clk;
  logic       clr;
  logic       prst;
  logic [3:0] q4;
  logic [7:0] q8;
  logic [3:0] qm;
  logic [3:0] qz;

  int n_checks = 0;
  int n_errors = 0;

  ring_counter #(.WIDTH(4)) dut4 (.in_clk(clk), .in_clr(clr), .in_prst(prst), .o_q(q4));
  ring_counter #(.WIDTH(8)) dut8 (.in_clk(clk), .in_clr(clr), .in_prst(prst), .o_q(q8));
  ring_counter #(.WIDTH(4), .SEED(4'b1010)) dutm (.in_clk(clk), .in_clr(clr), .in_prst(prst), .o_q(qm));
  ring_counter #(.WIDTH(4), .SEED(4'b0000)) dutz (.in_clk(clk), .in_clr(clr), .in_prst(prst), .o_q(qz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       prst;
    logic [3:0] exp4;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 4'b0100};
    vecs[1]  = '{1'b0, 1'b0, 4'b0010};
    vecs[2]  = '{1'b0, 1'b0, 4'b0001};
    vecs[3]  = '{1'b0, 1'b0, 4'b1000};
    vecs[4]  = '{1'b0, 1'b0, 4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 4'b0001};
    vecs[7]  = '{1'b0, 1'b1, 4'b1000};
    vecs[8]  = '{1'b0, 1'b1, 4'b1000};
    vecs[9]  = '{1'b0, 1'b1, 4'b1000};
    vecs[10] = '{1'b0, 1'b0, 4'b0100};
    vecs[11] = '{1'b0, 1'b1, 4'b1000};
    vecs[12] = '{1'b0, 1'b0, 4'b0100};
    vecs[13] = '{1'b0, 1'b0, 4'b0010};

    // Clear and preset overlap the first rising edge at t=5.
    clr  = 1'b1;
    prst = 1'b1;
    #1;
    chk("clr_async4", 32'(q4), 32'h8);
    chk("clr_async8", 32'(q8), 32'h80);
    @(posedge clk);
    #1;
    chk("clr_edge4", 32'(q4), 32'h8);
    clr  = 1'b0;
    prst = 1'b0;
    @(negedge clk);
    chk("clr_hold4", 32'(q4), 32'h8);
    chk("seed_multi", 32'(qm), 32'ha);
    chk("seed_zero", 32'(qz), 32'h0);

    for (int i = 0; i < 14; i++) begin
      clr  = vecs[i].clr;
      prst = vecs[i].prst;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(q4), 32'(vecs[i].exp4));
      if (i == 0) begin
`ifdef RCOUNTER_SELFCORRECT_EN
        chk("multi_edge", 32'(qm), 32'ha);
`else
        chk("multi_edge", 32'(qm), 32'h5);
`endif
        chk("zero_edge", 32'(qz), 32'h0);
      end
    end
    prst = 1'b0;

    // Clear pulse strictly between edges, q4 is 0010 here.
    #3;
    clr = 1'b1;
    #1;
    chk("mid_clr", 32'(q4), 32'h8);
    #1;
    clr = 1'b0;
    #1;
    chk("mid_clr_rel", 32'(q4), 32'h8);
    @(posedge clk);
    #1;
    chk("mid_clr_shift", 32'(q4), 32'h4);

    // Clear held across an edge discards that shift.
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_over_edge", 32'(q4), 32'h8);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("first_shift", 32'(q4), 32'h4);

    // WIDTH=8 full lap after a fresh clear.
    clr = 1'b1;
    #1;
    chk("w8_clr", 32'(q8), 32'h80);
    clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] exp8;
      exp8 = 8'h80 >> (k % 8);
      @(posedge clk);
      #1;
      chk($sformatf("w8_step%0d", k), 32'(q8), 32'(exp8));
      chk($sformatf("w8_onehot%0d", k), 32'(is_onehot(32'(q8))), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
